seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller sharing one hex-to-7-segment decode path across DIGITS
//  digit positions of the FPGA_NUM1 display. Sits between the counter datapath, which supplies
//  packed hex nibbles, and the display pins (scan select plus DP/a..g). Inserts a blanking
//  dead-time between digits to prevent ghosting. Uses a load/ack handshake so a value only
//  changes at frame boundaries.
// PARAMETERS
//  DIGITS     4     number of scanned digits (2..4); digit 0 = least significant
//  SEL_W      2     scan_select width; DIGITS <= 2**SEL_W
//  SCAN_DIV   1000  SHOW cycles per digit (>=1)
//  BLANK_CYC  2     BLANK cycles before each digit (>=1)
// PORTS
//  clock        in   1          single clock, all logic posedge
//  rst          in   1          synchronous reset, active-low
//  ena          in   1          1 = scan runs; 0 = freeze scan and blank segments
//  value        in   4*DIGITS   packed nibbles; [3:0] = digit 0
//  load         in   1          1-cycle request to display value
//  load_ack     out  1          1-cycle pulse: requested value now displayed
//  lz_blank     in   1          1 = suppress leading zeros
//  dp_mask      in   DIGITS     bit i = 1 lights DP on digit i
//  scan_select  out  SEL_W      index of the currently driven digit
//  seg7         out  8          [7]=DP, [6:0]=a..g, active-high
//  frame_start  out  1          1-cycle pulse at start of digit 0 of each frame
// BEHAVIOUR
//  Reset (rst=0 at edge): state=BLANK, idx=0, cnt=0, disp=0, pend=0, pend_v=0.
//   Outputs after reset: scan_select=0, seg7=0, load_ack=0, frame_start=0.
//  All outputs are registered and update on the same edge as state.
//  FSM, per digit slot:
//   BLANK: seg7=0 and scan_select=idx for BLANK_CYC cycles, then go to SHOW with cnt=0.
//   SHOW: seg7=enc(idx) for SCAN_DIV cycles.
//    At the end of SHOW, idx advances and the FSM enters BLANK.
//    If idx==DIGITS-1, idx wraps to 0 (frame boundary).
//  Frame period = DIGITS*(BLANK_CYC+SCAN_DIV) cycles.
//  frame_start is high during the first BLANK cycle of idx 0 entered by wrap. It does not
//   pulse after reset.
//  Encoding: enc(i)[6:0] = HEX[disp nibble i], using
//   0..F = 7E 30 6D 79 33 5B 5F 70 7F 7B 77 1F 4E 3D 4F 47 (bit6=a .. bit0=g).
//   enc(i)[7] = dp_mask[i].
//  Leading-zero blanking, when lz_blank=1: digit i>0 has [6:0]=0 if disp nibbles i..DIGITS-1
//   are all 0. Digit 0 is never blanked. DP is unaffected.
//  Handshake:
//   - load=1 captures value into pend and sets pend_v.
//   - A later load before transfer overwrites pend; the last value wins and only one ack
//     is given.
//   - Frame-boundary edge (SHOW end, idx DIGITS-1 -> 0):
//     * load=1 at that edge: disp <= value.
//     * else if pend_v: disp <= pend.
//     In either case pend_v <= 0 and load_ack = 1 during the next cycle (same cycle as
//     frame_start).
//   - No pending request: disp holds and there is no ack.
//   - disp never changes mid-frame.
//  ena=0: state, idx and cnt hold; seg7 is forced to 0; scan_select holds.
//   load is still captured into pend; transfer waits for the next boundary after ena returns.
//   ena returning to 1 resumes exactly where the scan froze.
//  Reset mid-frame or mid-handshake discards pend and disp. No ack is issued for a dropped
//   request.
//  Width: cnt is sized for max(SCAN_DIV, BLANK_CYC)-1. All counters wrap only by the FSM
//   rule, never by overflow.
// TESTING (DIGITS=4, SEL_W=2, SCAN_DIV=4, BLANK_CYC=2 -> frame = 24 cycles)
//  1. Release reset, ena=1 -> scan_select sequence 0,1,2,3, each held 6 cycles; seg7=0 in
//     the first 2 cycles of each slot; frame_start every 24 cycles; no pulse after reset.
//  2. load=1 with value=16'h12AF mid-frame -> display unchanged until boundary.
//     - Next frame: digit0=47, digit1=77, digit2=6D, digit3=30.
//     - load_ack high exactly 1 cycle, coincident with frame_start.
//  3. Two loads in one frame (16'h1111 then 16'h0305) -> 16'h0305 shown next frame;
//     exactly one load_ack.
//  4. lz_blank=1, value=16'h0007 -> digits 3,2,1 show seg7=00 and digit 0 shows 70.
//     - value=16'h0000 -> digit 0 shows 7E.
//     - dp_mask=4'b0100 -> digit 2 shows 80.
//  5. Drop ena for 10 cycles mid-SHOW of digit 2 -> seg7=0 and scan_select=2 held.
//     - On resume, the remaining SHOW cycles complete.
//     - The frame period stretches by exactly 10 cycles.
//  6. Assert rst=0 one cycle with a load pending -> all outputs 0 next cycle; no load_ack;
//     disp=0 (digit 0 shows 7E).

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a multi-digit 7-segment display.
// One hex decode path is shared across DIGITS positions. Each digit slot is a blanking
// dead-time (BLANK_CYC cycles, segments dark) followed by a SHOW window (SCAN_DIV cycles).
// New display values are accepted through a load/ack handshake. They are applied only at
// frame boundaries, so a frame never shows a mix of old and new digits.
//
// Ports:
//   clock        single clock, all logic on posedge
//   rst          synchronous reset, active-low
//   ena          1 = scan runs; 0 = scan frozen and segments dark
//   value        packed hex nibbles, [3:0] = digit 0 (least significant)
//   load         1-cycle request to display value
//   load_ack     1-cycle pulse when the requested value becomes visible
//   lz_blank     1 = suppress leading zeros (digit 0 is never suppressed)
//   dp_mask      bit i lights the decimal point of digit i
//   scan_select  index of the currently driven digit
//   seg7         [7]=DP, [6:0]=a..g, active-high
//   frame_start  1-cycle pulse at the start of digit 0 of each frame
module seg7_scan_ctrl #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  output logic                  load_ack,
  input  logic                  lz_blank,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [SEL_W-1:0]      scan_select,
  output logic [7:0]            seg7,
  output logic                  frame_start
);

  localparam int unsigned MaxCyc = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0]  BlankLast = CntW'(BLANK_CYC - 1);
  localparam logic [CntW-1:0]  ShowLast  = CntW'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] IdxLast   = SEL_W'(DIGITS - 1);

  typedef enum logic {StBlank, StShow} state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic                pend_v_q, pend_v_d;
  logic                wrap;
  logic                ack_d, fs_d;
  logic [7:0]          seg_d;
  logic [4*DIGITS-1:0] upper;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
      4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
      4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  default: s = 7'h47;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    wrap     = 1'b0;

    // Scan sequencing; ena=0 freezes the position completely.
    if (ena) begin
      unique case (state_q)
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StShow;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StShow: begin
          if (cnt_q == ShowLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            if (idx_q == IdxLast) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + SEL_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: ;
      endcase
    end

    // A load coinciding with the boundary bypasses pend and wins over an older request.
    if (wrap) begin
      if (load) begin
        disp_d = value;
      end else if (pend_v_q) begin
        disp_d = pend_q;
      end
      pend_v_d = 1'b0;
    end else if (load) begin
      pend_d   = value;
      pend_v_d = 1'b1;
    end

    ack_d = wrap & (load | pend_v_q);
    fs_d  = wrap;

    // Nibbles idx_d..DIGITS-1 shifted down; all-zero means idx_d is a leading zero.
    upper = disp_d >> {idx_d, 2'b00};
    seg_d = '0;
    if (ena && (state_d == StShow)) begin
      seg_d[7] = dp_mask[idx_d];
      if (!(lz_blank && (idx_d != '0) && (upper == '0))) begin
        seg_d[6:0] = hex7(upper[3:0]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q     <= StBlank;
      idx_q       <= '0;
      cnt_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_v_q    <= 1'b0;
      scan_select <= '0;
      seg7        <= '0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      scan_select <= idx_d;
      seg7        <= seg_d;
      load_ack    <= ack_d;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (4 digits, SCAN_DIV=4, BLANK_CYC=2, frame = 24).
// A reference model tracks the scan as a position on a 24-cycle frame timeline and pushes
// the expected outputs for every clock edge into a queue; a monitor pops them on the
// falling edge and compares against the DUT.
module tb_seg7_scan_ctrl;

  localparam int Digits = 4;
  localparam int ScanDiv = 4;
  localparam int BlankCyc = 2;
  localparam int Slot = ScanDiv + BlankCyc;
  localparam int Frame = Digits * Slot;

  localparam logic [6:0] HexTab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F,
                                         7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D,
                                         7'h4F, 7'h47};

  logic        clock = 1'b0;
  logic        rst, ena, load, lz_blank;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        load_ack, frame_start;
  logic [1:0]  scan_select;
  logic [7:0]  seg7;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] seg;
    logic       ack;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state.
  int          m_pos = 0;  // active (ena=1) cycles since reset
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  logic        m_pend_v = 1'b0;

  seg7_scan_ctrl #(
    .DIGITS   (Digits),
    .SEL_W    (2),
    .SCAN_DIV (ScanDiv),
    .BLANK_CYC(BlankCyc)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .ena        (ena),
    .value      (value),
    .load       (load),
    .load_ack   (load_ack),
    .lz_blank   (lz_blank),
    .dp_mask    (dp_mask),
    .scan_select(scan_select),
    .seg7       (seg7),
    .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] model_seg(int slot, logic [15:0] d, logic lz, logic [3:0] dp);
    int         hi;
    logic [7:0] r;
    hi = 0;
    for (int i = 0; i < Digits; i++) if (d[4*i +: 4] != 4'h0) hi = i;
    r = {dp[slot], HexTab[d[4*slot +: 4]]};
    if (lz && slot > hi) r[6:0] = 7'h00;
    return r;
  endfunction

  // Model: outputs after each edge, from the inputs sampled at that edge.
  always @(posedge clock) begin
    exp_t e;
    logic wrap;
    int   p;
    if (!rst) begin
      m_pos = 0;
      m_disp = '0;
      m_pend = '0;
      m_pend_v = 1'b0;
      e = '0;
    end else begin
      wrap = 1'b0;
      if (ena) begin
        m_pos++;
        wrap = (m_pos % Frame) == 0;
      end
      e.ack = wrap && (load || m_pend_v);
      e.fs = wrap;
      if (wrap) begin
        if (load) m_disp = value;
        else if (m_pend_v) m_disp = m_pend;
        m_pend_v = 1'b0;
      end else if (load) begin
        m_pend = value;
        m_pend_v = 1'b1;
      end
      p = m_pos % Frame;
      e.sel = 2'(p / Slot);
      e.seg = (ena && (p % Slot) >= BlankCyc) ?
              model_seg(p / Slot, m_disp, lz_blank, dp_mask) : 8'h00;
    end
    exp_q.push_back(e);
  end

  // Monitor.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp += 4;
      if (scan_select !== e.sel) begin
        n_bad++;
        $display("FAIL scan_select t=%0t: got %0d, expected %0d", $time, scan_select, e.sel);
      end
      if (seg7 !== e.seg) begin
        n_bad++;
        $display("FAIL seg7 t=%0t sel=%0d: got %h, expected %h", $time, e.sel, seg7, e.seg);
      end
      if (load_ack !== e.ack) begin
        n_bad++;
        $display("FAIL load_ack t=%0t: got %b, expected %b", $time, load_ack, e.ack);
      end
      if (frame_start !== e.fs) begin
        n_bad++;
        $display("FAIL frame_start t=%0t: got %b, expected %b", $time, frame_start, e.fs);
      end
    end
  end

  function automatic logic [15:0] rand_val();
    logic [15:0] v;
    v = 16'($urandom);
    return v >> (4 * $urandom_range(0, 4));
  endfunction

  task automatic cycles(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_load(logic [15:0] v);
    @(negedge clock);
    load = 1'b1;
    value = v;
    @(negedge clock);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    ena = 1'b0;
    load = 1'b0;
    lz_blank = 1'b0;
    value = '0;
    dp_mask = '0;
    cycles(3);
    rst = 1'b1;
    ena = 1'b1;
    // Plain scanning, no frame_start right after reset.
    cycles(60);
    // Single load mid-frame.
    pulse_load(16'h12AF);
    cycles(50);
    // Two loads in one frame; last value wins.
    cycles(3);
    pulse_load(16'h1111);
    cycles(4);
    pulse_load(16'h0305);
    cycles(50);
    // Leading-zero blanking and decimal point.
    lz_blank = 1'b1;
    pulse_load(16'h0007);
    cycles(50);
    pulse_load(16'h0000);
    cycles(50);
    dp_mask = 4'b0100;
    cycles(30);
    dp_mask = 4'b0000;
    lz_blank = 1'b0;
    pulse_load(16'h4321);
    cycles(30);
    // Freeze mid-SHOW of digit 2 (bounded search on the model timeline).
    for (int i = 0; i < 2 * Frame; i++) begin
      if ((m_pos % Frame) == 2 * Slot + BlankCyc + 1) break;
      @(negedge clock);
    end
    ena = 1'b0;
    cycles(10);
    ena = 1'b1;
    cycles(60);
    // Reset with a request pending.
    pulse_load(16'h9ABC);
    rst = 1'b0;
    cycles(1);
    rst = 1'b1;
    cycles(60);
    // Randomised traffic.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clock);
      rst = ($urandom_range(0, 599) != 0);
      ena = ($urandom_range(0, 15) != 0);
      load = ($urandom_range(0, 11) == 0);
      value = rand_val();
      if ($urandom_range(0, 99) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 99) == 0) dp_mask = 4'($urandom);
    end
    @(negedge clock);
    rst = 1'b1;
    ena = 1'b1;
    load = 1'b0;
    cycles(3);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
